// File: rtl/dbus_pkg.sv
// dbus_pkg: shared state encoding, region decode and device indices for the data-bus controller
package dbus_pkg;
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    typedef enum logic [2:0] {T_BRAM, T_UART, T_LED, T_SW, T_NONE} target_t;
    localparam logic [3:0] REG_UART = 4'b1011;
    localparam logic [3:0] REG_LED  = 4'b1100;
    localparam logic [3:0] REG_SW   = 4'b1101;
    localparam int UART = 0;
    localparam int LED  = 1;
    localparam int SW   = 2;
    function automatic target_t decode(input logic [3:0] r);
        return !r[3] ? T_BRAM : r == REG_UART ? T_UART : r == REG_LED ? T_LED : r == REG_SW ? T_SW : T_NONE;
    endfunction
    function automatic logic [1:0] dev_idx(input target_t t);
        return t == T_LED ? 2'(LED) : t == T_SW ? 2'(SW) : 2'(UART);
    endfunction
endpackage

// File: rtl/dbus_controller_watchdog.sv
// bus_watchdog: counts access cycles and flags expiry on the last permitted cycle
module bus_watchdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    logic [15:0] count;
    always_ff @(posedge clock) begin
        if (reset || clear) count <= 16'd0;
        else if (enable) count <= count + 16'd1;
    end
    assign expired = enable && count == 16'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/dbus_controller.sv
// dbus_controller: single-outstanding data-bus sequencer from the CPU data port to BRAM and three I/O devices
module dbus_controller
    import dbus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int ERRCNT_W = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [29:0]         cpu_addr,
    input  logic                cpu_read,
    input  logic [3:0]          cpu_we,
    input  logic [31:0]         cpu_wdata,
    output logic [31:0]         cpu_rdata,
    output logic                cpu_ack,
    output logic                mem_re,
    output logic [3:0]          mem_we,
    input  logic [31:0]         mem_rdata,
    input  logic                mem_ack,
    output logic [2:0]          io_re,
    output logic [2:0]          io_we,
    input  logic [95:0]         io_rdata,
    input  logic [2:0]          io_ack,
    output logic [31:0]         io_wdata,
    output logic [29:0]         io_addr,
    output logic                bus_error,
    output logic [ERRCNT_W-1:0] err_count,
    output logic [29:0]         err_addr
);
    state_t      state;
    target_t     tgt, dec;
    logic        wr, req, is_wr, bad, sel_ack, expired, fail;
    logic [1:0]  idx;
    logic [31:0] sel_data;

    bus_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
        .clock(clock),
        .reset(reset),
        .clear(state != ACCESS),
        .enable(state == ACCESS),
        .expired(expired)
    );

    always_comb begin
        is_wr = cpu_we != 4'h0;
        req = cpu_read || is_wr;
        dec = decode(cpu_addr[29:26]);
        bad = dec == T_NONE || (dec != T_BRAM && is_wr && cpu_we != 4'hF);
        idx = dev_idx(tgt);
        sel_ack = tgt == T_BRAM ? mem_ack : io_ack[idx];
        sel_data = tgt == T_BRAM ? mem_rdata : io_rdata[{idx, 5'b0} +: 32];
        // an ack coinciding with expiry completes normally
        fail = (state == IDLE && req && bad) || (state == ACCESS && !sel_ack && expired);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            tgt       <= T_BRAM;
            wr        <= 1'b0;
            cpu_rdata <= 32'h0;
            cpu_ack   <= 1'b0;
            bus_error <= 1'b0;
            mem_re    <= 1'b0;
            mem_we    <= 4'h0;
            io_re     <= 3'b0;
            io_we     <= 3'b0;
            io_wdata  <= 32'h0;
            io_addr   <= 30'h0;
            err_count <= '0;
            err_addr  <= 30'h0;
        end else begin
            case (state)
                IDLE: if (req) begin
                    io_addr  <= cpu_addr;
                    io_wdata <= cpu_wdata;
                    wr       <= is_wr;
                    tgt      <= dec;
                    if (bad) begin
                        state   <= DONE;
                        cpu_ack <= 1'b1;
                    end else begin
                        state  <= ACCESS;
                        mem_re <= dec == T_BRAM && !is_wr;
                        mem_we <= dec == T_BRAM ? cpu_we : 4'h0;
                        io_re  <= dec != T_BRAM && !is_wr ? 3'b1 << dev_idx(dec) : 3'b0;
                        io_we  <= dec != T_BRAM && is_wr ? 3'b1 << dev_idx(dec) : 3'b0;
                    end
                end
                ACCESS: if (sel_ack || expired) begin
                    state   <= DONE;
                    cpu_ack <= 1'b1;
                    mem_re  <= 1'b0;
                    mem_we  <= 4'h0;
                    io_re   <= 3'b0;
                    io_we   <= 3'b0;
                    if (sel_ack) cpu_rdata <= wr ? 32'h0 : sel_data;
                end
                default: begin
                    state     <= IDLE;
                    cpu_ack   <= 1'b0;
                    bus_error <= 1'b0;
                end
            endcase
            if (fail) begin
                bus_error <= 1'b1;
                cpu_rdata <= 32'h0;
                err_addr  <= state == IDLE ? cpu_addr : io_addr;
                err_count <= &err_count ? err_count : err_count + ERRCNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_dbus_controller.sv
// tb_dbus_controller: directed vector table plus hand sequences for timeout, reset and saturation
module tb_dbus_controller;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [29:0] cpu_addr = '0;
    logic        cpu_read = 1'b0;
    logic [3:0]  cpu_we = '0;
    logic [31:0] cpu_wdata = '0;
    logic [31:0] cpu_rdata;
    logic        cpu_ack;
    logic        mem_re;
    logic [3:0]  mem_we;
    logic [31:0] mem_rdata = 32'hBAD0_0000;
    logic        mem_ack = 1'b0;
    logic [2:0]  io_re, io_we;
    logic [95:0] io_rdata = {32'hBAD0_0002, 32'hBAD0_0001, 32'hBAD0_0000};
    logic [2:0]  io_ack = '0;
    logic [31:0] io_wdata;
    logic [29:0] io_addr;
    logic        bus_error;
    logic [7:0]  err_count;
    logic [29:0] err_addr;

    dbus_controller #(.TIMEOUT_CYCLES(8), .ERRCNT_W(8)) dut (
        .clock(clock), .reset(reset), .cpu_addr(cpu_addr), .cpu_read(cpu_read),
        .cpu_we(cpu_we), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .mem_re(mem_re), .mem_we(mem_we), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .io_re(io_re), .io_we(io_we), .io_rdata(io_rdata), .io_ack(io_ack),
        .io_wdata(io_wdata), .io_addr(io_addr), .bus_error(bus_error),
        .err_count(err_count), .err_addr(err_addr)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [29:0] addr;
        logic        rd;
        logic [3:0]  we;
        logic [31:0] wdata;
        int          delay;
        logic [3:0]  ack;
        logic [3:0]  stray;
        logic [31:0] rdata;
        logic [10:0] exp_strobe;
        int          exp_hold;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t        vecs[12];
    int          tests = 0;
    int          failed = 0;
    int          exp_cnt = 0;
    logic [29:0] exp_eaddr = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [10:0] strobes();
        return {mem_re, mem_we, io_re, io_we};
    endfunction

    task automatic note_error(input logic [29:0] a);
        exp_cnt = exp_cnt == 255 ? 255 : exp_cnt + 1;
        exp_eaddr = a;
    endtask

    task automatic run_vec(input int i, input vec_t v);
        int n = 0;
        logic got = 1'b0, stable = 1'b1, ack_err = 1'b0;
        logic [10:0] pat = '0;
        logic [31:0] ack_rd = '0, seen_wd = '0;
        logic [29:0] seen_addr = '0;
        @(negedge clock);
        cpu_addr = v.addr; cpu_read = v.rd; cpu_we = v.we; cpu_wdata = v.wdata;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clock);
            mem_ack = 1'b0; io_ack = 3'b0;
            mem_rdata = 32'hBAD0_0000;
            io_rdata = {32'hBAD0_0002, 32'hBAD0_0001, 32'hBAD0_0000};
            if (cpu_ack) begin
                got = 1'b1; ack_rd = cpu_rdata; ack_err = bus_error;
            end else if (strobes() != 0) begin
                if (n == 0) begin
                    pat = strobes(); seen_addr = io_addr; seen_wd = io_wdata;
                end else if (strobes() != pat) stable = 1'b0;
                n++;
                if (n == 1) {io_ack, mem_ack} = v.stray;
                if (n == v.delay) begin
                    {io_ack, mem_ack} = v.ack;
                    if (v.ack[0]) mem_rdata = v.rdata;
                    for (int k = 0; k < 3; k++) if (v.ack[k+1]) io_rdata[32*k +: 32] = v.rdata;
                end
            end
        end
        cpu_read = 1'b0; cpu_we = 4'h0;
        if (v.exp_err) note_error(v.addr);
        check($sformatf("v%0d ack_seen", i), 32'(got), 32'd1);
        check($sformatf("v%0d strobe_cycles", i), n, v.exp_hold);
        check($sformatf("v%0d strobe_pattern", i), 32'(pat), 32'(v.exp_strobe));
        check($sformatf("v%0d strobe_stable", i), 32'(stable), 32'd1);
        check($sformatf("v%0d cpu_rdata", i), ack_rd, v.exp_rdata);
        check($sformatf("v%0d bus_error", i), 32'(ack_err), 32'(v.exp_err));
        check($sformatf("v%0d err_count", i), 32'(err_count), exp_cnt);
        check($sformatf("v%0d err_addr", i), 32'(err_addr), 32'(exp_eaddr));
        if (v.exp_strobe != 0) begin
            check($sformatf("v%0d io_addr", i), 32'(seen_addr), 32'(v.addr));
            if (v.we != 0) check($sformatf("v%0d io_wdata", i), seen_wd, v.wdata);
        end
        @(negedge clock);
        check($sformatf("v%0d ack_pulse", i), 32'(cpu_ack), 32'd0);
    endtask

    initial begin
        vecs[0]  = '{30'h0000010, 1'b1, 4'h0, 32'h0,        3, 4'b0001, 4'b0000, 32'hDEADBEEF, 11'b1_0000_000_000, 3, 32'hDEADBEEF, 1'b0};
        vecs[1]  = '{30'h30000000, 1'b0, 4'hF, 32'h000000A5, 1, 4'b0100, 4'b0000, 32'h0,        11'b0_0000_000_010, 1, 32'h0,        1'b0};
        vecs[2]  = '{30'h38000000, 1'b1, 4'h0, 32'h0,        0, 4'b0000, 4'b0000, 32'h0,        11'b0_0000_000_000, 0, 32'h0,        1'b1};
        vecs[3]  = '{30'h2C000004, 1'b1, 4'h0, 32'h0,        0, 4'b0000, 4'b0000, 32'h0,        11'b0_0000_001_000, 8, 32'h0,        1'b1};
        vecs[4]  = '{30'h2C000000, 1'b1, 4'h0, 32'h0,        4, 4'b0010, 4'b1001, 32'h12345678, 11'b0_0000_001_000, 4, 32'h12345678, 1'b0};
        vecs[5]  = '{30'h34000008, 1'b1, 4'h0, 32'h0,        2, 4'b1000, 4'b0000, 32'hCAFEF00D, 11'b0_0000_100_000, 2, 32'hCAFEF00D, 1'b0};
        vecs[6]  = '{30'h0000020, 1'b0, 4'h3, 32'h11223344,  1, 4'b0001, 4'b0000, 32'h0,        11'b0_0011_000_000, 1, 32'h0,        1'b0};
        vecs[7]  = '{30'h2C000000, 1'b0, 4'h1, 32'h77,       0, 4'b0000, 4'b0000, 32'h0,        11'b0_0000_000_000, 0, 32'h0,        1'b1};
        vecs[8]  = '{30'h0000005, 1'b1, 4'hF, 32'hA0B0C0D0,  2, 4'b0001, 4'b0000, 32'h55,       11'b0_1111_000_000, 2, 32'h0,        1'b0};
        vecs[9]  = '{30'h30000001, 1'b1, 4'h0, 32'h0,        1, 4'b0100, 4'b0000, 32'h000000FF, 11'b0_0000_010_000, 1, 32'h000000FF, 1'b0};
        vecs[10] = '{30'h2C000000, 1'b1, 4'h0, 32'h0,        8, 4'b0010, 4'b0000, 32'h600DF00D, 11'b0_0000_001_000, 8, 32'h600DF00D, 1'b0};
        vecs[11] = '{30'h1FFFFFFF, 1'b1, 4'h0, 32'h0,        1, 4'b0001, 4'b0000, 32'h00000001, 11'b1_0000_000_000, 1, 32'h00000001, 1'b0};

        repeat (2) @(negedge clock);
        reset = 1'b0;
        check("rst cpu_ack", 32'(cpu_ack), 32'd0);
        check("rst bus_error", 32'(bus_error), 32'd0);
        check("rst cpu_rdata", cpu_rdata, 32'd0);
        check("rst strobes", 32'(strobes()), 32'd0);
        check("rst io_addr", 32'(io_addr), 32'd0);
        check("rst io_wdata", io_wdata, 32'd0);
        check("rst err_count", 32'(err_count), 32'd0);
        check("rst err_addr", 32'(err_addr), 32'd0);

        for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

        // timeout followed by a late UART ack that must not start or finish anything
        begin
            logic got = 1'b0;
            @(negedge clock);
            cpu_addr = 30'h2C000010; cpu_read = 1'b1;
            for (int c = 0; c < 20 && !got; c++) begin
                @(negedge clock);
                got = cpu_ack;
            end
            cpu_read = 1'b0;
            note_error(30'h2C000010);
            check("late ack_seen", 32'(got), 32'd1);
            check("late bus_error", 32'(bus_error), 32'd1);
            check("late err_count", 32'(err_count), exp_cnt);
            io_ack = 3'b001;
            for (int c = 0; c < 2; c++) begin
                @(negedge clock);
                check("late no_ack", 32'(cpu_ack), 32'd0);
                check("late no_strobe", 32'(strobes()), 32'd0);
            end
            io_ack = 3'b000;
        end

        // reset while a BRAM read is pending
        @(negedge clock);
        cpu_addr = 30'h0000040; cpu_read = 1'b1;
        repeat (2) @(negedge clock);
        check("midrst strobe_before", 32'(mem_re), 32'd1);
        reset = 1'b1; cpu_read = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        exp_cnt = 0; exp_eaddr = '0;
        check("midrst strobes", 32'(strobes()), 32'd0);
        check("midrst err_count", 32'(err_count), 32'd0);
        check("midrst cpu_ack", 32'(cpu_ack), 32'd0);
        mem_ack = 1'b1;
        @(negedge clock);
        mem_ack = 1'b0;
        check("midrst late_ack", 32'(cpu_ack), 32'd0);
        @(negedge clock);
        check("midrst idle", 32'(cpu_ack | mem_re), 32'd0);

        // 300 back-to-back unmapped reads saturate the error counter
        begin
            int errs = 0;
            cpu_addr = 30'h3C000000; cpu_read = 1'b1;
            for (int c = 0; c < 700 && errs < 300; c++) begin
                @(negedge clock);
                if (cpu_ack && bus_error) errs++;
            end
            cpu_read = 1'b0;
            check("sat errors_seen", errs, 300);
            @(negedge clock);
            check("sat err_count", 32'(err_count), 32'd255);
            check("sat err_addr", 32'(err_addr), 32'(30'h3C000000));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/dbus_controller.md
Name: dbus_controller

Overview:
Registered data-bus controller between the MIPS32 data-memory port and its slaves: on-chip BRAM port B plus three memory-mapped I/O devices (UART, LED, Switches). Decodes the word address and sequences a single-outstanding, hold-until-ack transaction to exactly one slave. Returns registered read data and a one-cycle ack to the CPU. A watchdog terminates hung accesses, and unmapped addresses complete as bus errors instead of stalling the core.

Parameters:
TIMEOUT_CYCLES, 255, cycles in ACCESS without slave ack before the access is aborted (1..65535)
ERRCNT_W, 8, width of the saturating bus-error counter

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
cpu_addr  in  30  word address, held by CPU until cpu_ack
cpu_read  in  1  read request level
cpu_we  in  4  byte write enables; nonzero = write request
cpu_wdata  in  32  write data
cpu_rdata  out  32  read data, valid when cpu_ack=1
cpu_ack  out  1  one-cycle transaction-complete pulse
mem_re  out  1  BRAM read strobe
mem_we  out  4  BRAM byte write enables
mem_rdata  in  32  BRAM read data
mem_ack  in  1  BRAM ack
io_re  out  3  per-device read strobe (0=UART, 1=LED, 2=Switches)
io_we  out  3  per-device write strobe (full-word writes only)
io_rdata  in  96  packed device read data, device n at [32n+31:32n]
io_ack  in  3  per-device ack
io_wdata  out  32  registered write data to all slaves (BRAM and I/O)
io_addr  out  30  registered transaction address to all slaves
bus_error  out  1  one-cycle pulse, coincident with the cpu_ack of a failed access
err_count  out  ERRCNT_W  saturating count of bus errors
err_addr  out  30  address of the most recent failed access

Behaviour:
- Reset: state IDLE; all strobes, cpu_ack and bus_error are 0; cpu_rdata, io_wdata, io_addr, err_addr and err_count are 0. Reset mid-transaction drops every strobe on the next edge; any late slave ack is ignored.
- Decode on cpu_addr[29:26]:
  - 0xxx selects BRAM.
  - 1011 selects UART.
  - 1100 selects LED.
  - 1101 selects Switches.
  - Any other value is unmapped.
- I/O write qualification: an I/O write requires cpu_we=4'hF. A partial-byte write to I/O is a bus error.
- IDLE:
  - A request is cpu_read=1 or cpu_we!=0. On a request, latch addr, wdata, type and target.
  - Valid target goes to ACCESS.
  - Unmapped target or bad I/O write goes to DONE with the error flag set.
  - cpu_read and cpu_we both active: the write takes precedence and the read is ignored.
- ACCESS:
  - Exactly one strobe is asserted (mem_re/mem_we or one io_re/io_we bit), held constant until the selected ack arrives or the watchdog fires.
  - On the selected ack: capture rdata (read) or 0 (write), drop the strobe, go to DONE.
  - Acks from non-selected slaves are ignored.
- Watchdog: resets to 0 on ACCESS entry and increments each ACCESS cycle. When it reaches TIMEOUT_CYCLES-1 without an ack: drop the strobe, set the error flag, go to DONE. An ack on that same cycle wins; the access completes with no error.
- DONE:
  - cpu_ack=1 for exactly one cycle. cpu_rdata holds the captured data, or 0 on error.
  - If the error flag is set: bus_error=1, err_addr is updated, and err_count increments, saturating at all-ones.
  - Next state is IDLE.
- CPU contract: the request is deasserted or changed in the cycle after cpu_ack. A request level still present in IDLE is a new transaction.
- Latency:
  - Request sampled at edge 0, strobe visible after edge 0, slave ack at edge k, cpu_ack visible after edge k+1.
  - Minimum CPU-visible latency is 2 cycles.
  - An unmapped access acks after 1 cycle.
- cpu_rdata holds its last value outside cpu_ack.

Decomposition:
- Package dbus_pkg:
  - state encoding IDLE/ACCESS/DONE
  - region codes REG_UART=4'b1011, REG_LED=4'b1100, REG_SW=4'b1101
  - device indices UART=0, LED=1, SW=2
- Sub-module bus_watchdog (TIMEOUT_CYCLES):
  - inputs clear and enable
  - output expired

Test Plan:
- BRAM read at addr 0x0000010, mem_ack 3 cycles after mem_re with mem_rdata=0xDEADBEEF -> mem_re held 3 cycles; cpu_ack one cycle later with cpu_rdata=0xDEADBEEF; bus_error=0.
- LED write at addr 0x30000000 with cpu_we=F and wdata=0x000000A5, io_ack[1] after 1 cycle -> io_we=3'b010 and io_wdata=0xA5; cpu_ack after 1 cycle.
- Unmapped read at 0x38000000 -> no strobe asserted; cpu_ack and bus_error 1 cycle after request; cpu_rdata=0; err_addr=0x38000000; err_count=1.
- UART read with no ack and TIMEOUT_CYCLES=8 -> io_re[0] held exactly 8 cycles; then cpu_ack with bus_error; a late io_ack is ignored.
- Stray acks: io_ack[2] and mem_ack pulsed during a pending UART read -> ignored; completion only on io_ack[0].
- Reset and saturation:
  - Reset asserted mid-ACCESS -> next cycle all strobes are 0, state is IDLE, err_count is 0.
  - 300 consecutive errors -> err_count saturates at 255.
